// File: rtl/mux4_scanner.sv
// Walks the 4:1 mux selects through channels 0..3, holding each for DWELL cycles and sampling y at dwell end.
// Start-to-word_valid latency is 4*DWELL cycles; no backpressure, word_valid is a one-cycle pulse.
module mux4_scanner #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode,
  input  logic       stop,
  input  logic       abort,
  input  logic       y,
  output logic       s1,
  output logic       s0,
  output logic [3:0] word,
  output logic       word_valid,
  output logic       busy,
  output logic [7:0] frames
);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);

  state_t           state_q, state_d;
  logic [1:0]       chan_q, chan_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cont_q, cont_d;
  logic [2:0]       shadow_q, shadow_d;
  logic [3:0]       word_q, word_d;
  logic             word_valid_q, word_valid_d;
  logic [7:0]       frames_q, frames_d;

  logic expire;
  logic last_chan;

  assign expire    = (state_q == SCAN) && !abort && (cnt_q == '0);
  assign last_chan = (chan_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      chan_q       <= 2'd0;
      cnt_q        <= '0;
      cont_q       <= 1'b0;
      shadow_q     <= 3'd0;
      word_q       <= 4'd0;
      word_valid_q <= 1'b0;
      frames_q     <= 8'd0;
    end else begin
      state_q      <= state_d;
      chan_q       <= chan_d;
      cnt_q        <= cnt_d;
      cont_q       <= cont_d;
      shadow_q     <= shadow_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      frames_q     <= frames_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start && !abort) state_d = SCAN;
      SCAN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (expire && last_chan && !(cont_q && !stop)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    chan_d       = chan_q;
    cnt_d        = cnt_q;
    cont_d       = cont_q;
    shadow_d     = shadow_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    frames_d     = frames_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          chan_d   = 2'd0;
          cnt_d    = RELOAD;
          cont_d   = mode;
          shadow_d = 3'd0;
        end
      end
      SCAN: begin
        if (stop) cont_d = 1'b0;
        if (abort) begin
          chan_d   = 2'd0;
          shadow_d = 3'd0;
          cont_d   = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!last_chan) begin
          shadow_d[chan_q] = y;
          chan_d           = chan_q + 2'd1;
          cnt_d            = RELOAD;
        end else begin
          // Channel 3 goes straight into word; the shadow only holds 0..2.
          word_d       = {y, shadow_q};
          word_valid_d = 1'b1;
          frames_d     = frames_q + 8'd1;
          chan_d       = 2'd0;
          cnt_d        = RELOAD;
          shadow_d     = 3'd0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy       = (state_q == SCAN);
    s1         = chan_q[1];
    s0         = chan_q[0];
    word       = word_q;
    word_valid = word_valid_q;
    frames     = frames_q;
  end

endmodule
